// File: rtl/mmips_pkg.sv
`default_nettype none
// ============================================================================
// mmips_pkg : opcode/funct constants, ALU-op codes and control bundle type
// Rev 1.0
// ============================================================================
package mmips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic       signextend;
        logic       regdst;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage : mmips_pkg
`default_nettype wire

// File: rtl/main_ctrl_decode.sv
`default_nettype none
// ============================================================================
// main_ctrl_decode : combinational opcode/funct to control-bundle decoder
// Rev 1.0
// ============================================================================
module main_ctrl_decode
    import mmips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NONE;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = ALUOP_FUNCT;
                if (funct_i == FN_JR) begin
                    ctrl_o.regwrite = 1'b0;
                    ctrl_o.jump     = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.memread    = 1'b1;
                ctrl_o.memtoreg   = 1'b1;
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.aluop      = ALUOP_ADD;
                ctrl_o.signextend = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.memwrite   = 1'b1;
                ctrl_o.aluop      = ALUOP_ADD;
                ctrl_o.signextend = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o.branch     = 1'b1;
                ctrl_o.aluop      = ALUOP_SUB;
                ctrl_o.signextend = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.aluop      = ALUOP_ADD;
                ctrl_o.signextend = 1'b1;
            end
            // Logical immediates and lui zero-extend their operand
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = ALUOP_LOGIC;
            end
            OP_J: begin
                ctrl_o.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.jump     = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule : main_ctrl_decode
`default_nettype wire

// File: rtl/if_id_decode.sv
`default_nettype none
// ============================================================================
// if_id_decode : IF/ID pipeline register with registered field/control decode
// Rev 1.0
// ============================================================================
module if_id_decode
    import mmips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        out_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] target26,
    output logic        signextend,
    output logic        regdst,
    output logic        alusrc,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        branch,
    output logic        jump,
    output logic [1:0]  aluop,
    output logic        illegal
);

    ctrl_t       dec_ctrl;
    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_d,    pc_q;
    logic        valid_d, valid_q;
    ctrl_t       ctrl_d,  ctrl_q;

    main_ctrl_decode u_main_ctrl_decode (
        .opcode_i (instr_in[31:26]),
        .funct_i  (instr_in[5:0]),
        .ctrl_o   (dec_ctrl)
    );

    // flush > stall > load; a bubble leaves pc untouched
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        if (flush || (!stall && !in_valid)) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            ctrl_d  = CTRL_NONE;
        end else if (!stall) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_WORD;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NONE;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign instr_out  = instr_q;
    assign pc_out     = pc_q;
    assign out_valid  = valid_q;

    assign opcode     = instr_q[31:26];
    assign rs         = instr_q[25:21];
    assign rt         = instr_q[20:16];
    assign rd         = instr_q[15:11];
    assign shamt      = instr_q[10:6];
    assign funct      = instr_q[5:0];
    assign imm16      = instr_q[15:0];
    assign target26   = instr_q[25:0];

    assign signextend = ctrl_q.signextend;
    assign regdst     = ctrl_q.regdst;
    assign alusrc     = ctrl_q.alusrc;
    assign memread    = ctrl_q.memread;
    assign memwrite   = ctrl_q.memwrite;
    assign memtoreg   = ctrl_q.memtoreg;
    assign regwrite   = ctrl_q.regwrite;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign aluop      = ctrl_q.aluop;
    assign illegal    = ctrl_q.illegal;

endmodule : if_id_decode
`default_nettype wire

// File: tb/tb_if_id_decode.sv
`default_nettype none
// ============================================================================
// tb_if_id_decode : table-driven self-checking bench for if_id_decode
// Rev 1.0
// ============================================================================
module tb_if_id_decode;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        out_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic        signextend;
    logic        regdst;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
    logic        branch;
    logic        jump;
    logic [1:0]  aluop;
    logic        illegal;

    if_id_decode dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .pc_in      (pc_in),
        .in_valid   (in_valid),
        .stall      (stall),
        .flush      (flush),
        .instr_out  (instr_out),
        .pc_out     (pc_out),
        .out_valid  (out_valid),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm16      (imm16),
        .target26   (target26),
        .signextend (signextend),
        .regdst     (regdst),
        .alusrc     (alusrc),
        .memread    (memread),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .branch     (branch),
        .jump       (jump),
        .aluop      (aluop),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {signextend, regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch, jump, aluop[1:0], illegal}
    logic [11:0] w_ctrl;
    assign w_ctrl = {signextend, regdst, alusrc, memread, memwrite, memtoreg,
                     regwrite, branch, jump, aluop, illegal};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        iv;
        logic        st;
        logic        fl;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [11:0] exp_ctrl;
    } vec_t;

    vec_t r_vec[19];
    int   r_checks;
    int   r_passed;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic iv, input logic st, input logic fl,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic ev, input logic [11:0] ec);
        vec_t v;
        v.instr = instr; v.pc = pc; v.iv = iv; v.st = st; v.fl = fl;
        v.exp_instr = ei; v.exp_pc = ep; v.exp_valid = ev; v.exp_ctrl = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        r_checks++;
        if (act === exp) r_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_state(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                               input logic ev, input logic [11:0] ec);
        check({tag, ".instr_out"}, instr_out, ei);
        check({tag, ".pc_out"}, pc_out, ep);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({tag, ".ctrl"}, {20'd0, w_ctrl}, {20'd0, ec});
        check({tag, ".fields"}, {opcode, rs, rt, rd, shamt, funct}, ei);
        check({tag, ".imm16"}, {16'd0, imm16}, {16'd0, ei[15:0]});
        check({tag, ".target26"}, {6'd0, target26}, {6'd0, ei[25:0]});
    endtask

    initial begin
        r_checks = 0;
        r_passed = 0;

        //                instr         pc     iv st fl  exp_instr     exp_pc v  ctrl
        r_vec[0]  = mk(32'h2008FFFF, 32'h04, 1, 0, 0, 32'h2008FFFF, 32'h04, 1, 12'hA20); // addi
        r_vec[1]  = mk(32'h3508F00F, 32'h08, 1, 0, 0, 32'h3508F00F, 32'h08, 1, 12'h226); // ori
        r_vec[2]  = mk(32'h8D090004, 32'h0C, 1, 0, 0, 32'h8D090004, 32'h0C, 1, 12'hB60); // lw
        r_vec[3]  = mk(32'h1109FFFE, 32'h10, 1, 0, 0, 32'h1109FFFE, 32'h10, 1, 12'h812); // beq
        r_vec[4]  = mk(32'h8D090004, 32'h50, 1, 1, 0, 32'h1109FFFE, 32'h10, 1, 12'h812); // stall
        r_vec[5]  = mk(32'h00000000, 32'h54, 0, 1, 0, 32'h1109FFFE, 32'h10, 1, 12'h812); // stall
        r_vec[6]  = mk(32'hFC000000, 32'h58, 1, 1, 0, 32'h1109FFFE, 32'h10, 1, 12'h812); // stall
        r_vec[7]  = mk(32'hAD090008, 32'h14, 1, 0, 0, 32'hAD090008, 32'h14, 1, 12'hA80); // sw
        r_vec[8]  = mk(32'h2008FFFF, 32'h18, 1, 1, 1, 32'h00000000, 32'h14, 0, 12'h000); // stall+flush
        r_vec[9]  = mk(32'hFC000000, 32'h1C, 1, 0, 0, 32'hFC000000, 32'h1C, 1, 12'h001); // illegal
        r_vec[10] = mk(32'h2008FFFF, 32'h20, 0, 0, 0, 32'h00000000, 32'h1C, 0, 12'h000); // in_valid=0
        r_vec[11] = mk(32'h012A4020, 32'h24, 1, 0, 0, 32'h012A4020, 32'h24, 1, 12'h424); // add
        r_vec[12] = mk(32'h03E00008, 32'h28, 1, 0, 0, 32'h03E00008, 32'h28, 1, 12'h40C); // jr
        r_vec[13] = mk(32'h08000010, 32'h2C, 1, 0, 0, 32'h08000010, 32'h2C, 1, 12'h008); // j
        r_vec[14] = mk(32'h0C000010, 32'h30, 1, 0, 0, 32'h0C000010, 32'h30, 1, 12'h028); // jal
        r_vec[15] = mk(32'h1509FFFC, 32'h34, 1, 0, 0, 32'h1509FFFC, 32'h34, 1, 12'h812); // bne
        r_vec[16] = mk(32'h3C081234, 32'h38, 1, 0, 0, 32'h3C081234, 32'h38, 1, 12'h226); // lui
        r_vec[17] = mk(32'h2008FFFF, 32'h3C, 1, 0, 1, 32'h00000000, 32'h38, 0, 12'h000); // flush
        r_vec[18] = mk(32'h8D090004, 32'h40, 1, 0, 0, 32'h8D090004, 32'h40, 1, 12'hB60); // lw

        rst      = 1'b1;
        instr_in = 32'h2008FFFF;
        pc_in    = 32'h04;
        in_valid = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 32'h0, 32'h0, 1'b0, 12'h000);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            instr_in = r_vec[i].instr;
            pc_in    = r_vec[i].pc;
            in_valid = r_vec[i].iv;
            stall    = r_vec[i].st;
            flush    = r_vec[i].fl;
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), r_vec[i].exp_instr, r_vec[i].exp_pc,
                        r_vec[i].exp_valid, r_vec[i].exp_ctrl);
            @(negedge clk);
        end

        // Hold lw under stall, then hit reset mid-cycle with no clock edge
        stall    = 1'b1;
        instr_in = 32'h3508F00F;
        pc_in    = 32'h44;
        @(posedge clk);
        #1;
        check_state("stall_lw", 32'h8D090004, 32'h40, 1'b1, 12'hB60);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 32'h0, 32'h0, 1'b0, 12'h000);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("rst_then_stall", 32'h0, 32'h0, 1'b0, 12'h000);

        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        check_state("resume_ori", 32'h3508F00F, 32'h44, 1'b1, 12'h226);

        $display("%0d/%0d checks passed", r_passed, r_checks);
        $finish;
    end

endmodule : tb_if_id_decode
`default_nettype wire
